// File: rtl/controle_banco_reg_pkg.sv
// Shared types and constants for the register-bank sequencer: FSM states,
// calculator op codes and bank register addresses.
package calc_pkg;

  localparam int LARGURA_BANCO = 32;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    ESC_A      = 4'd1,
    ESC_B      = 4'd2,
    LER        = 4'd3,
    ESPERA     = 4'd4,
    ESC_ACC    = 4'd5,
    LER_ACC    = 4'd6,
    ESPERA_ACC = 4'd7,
    FIM        = 4'd8
  } estado_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_ACC = 2'b10;

endpackage

// File: rtl/controle_banco_reg_if.sv
// Calculator command and register-bank signals of the sequencer. master is the
// sequencer's view; slave is the view of the front-end and bank around it.
interface controle_banco_reg_if
  import calc_pkg::*;
#(
  parameter int LARGURA = LARGURA_BANCO
);
  logic               Inicio;
  logic [LARGURA-1:0] OperandoA;
  logic [LARGURA-1:0] OperandoB;
  logic [1:0]         Op;
  logic [1:0]         IdReg;
  logic               Escrita;
  logic [LARGURA-1:0] Dado;
  logic [1:0]         Fonte1;
  logic [1:0]         Fonte2;
  logic [LARGURA-1:0] DadoLido1;
  logic [LARGURA-1:0] DadoLido2;
  logic [LARGURA-1:0] Resultado;
  logic               Ocupado;
  logic               Pronto;
  logic               Overflow;
  logic               Erro;

  modport master (
    input  Inicio, OperandoA, OperandoB, Op, DadoLido1, DadoLido2,
    output IdReg, Escrita, Dado, Fonte1, Fonte2,
    output Resultado, Ocupado, Pronto, Overflow, Erro
  );

  modport slave (
    output Inicio, OperandoA, OperandoB, Op, DadoLido1, DadoLido2,
    input  IdReg, Escrita, Dado, Fonte1, Fonte2,
    input  Resultado, Ocupado, Pronto, Overflow, Erro
  );
endinterface

// File: rtl/controle_banco_reg_ula.sv
// Combinational ALU: add, sub (a - b), and, or, modulo 2^LARGURA, with signed
// overflow reported for add/sub only.
module calc_ula
  import calc_pkg::*;
#(
  parameter int LARGURA = LARGURA_BANCO
) (
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic [1:0]         op,
  output logic [LARGURA-1:0] resultado,
  output logic               overflow
);

  localparam int MSB = LARGURA - 1;

  // result and overflow per op code
  always_comb begin
    resultado = {LARGURA{1'b0}};
    overflow  = 1'b0;
    case (op)
      OP_ADD: begin
        resultado = a + b;
        overflow  = (a[MSB] == b[MSB]) && (resultado[MSB] != a[MSB]);
      end
      OP_SUB: begin
        resultado = a - b;
        overflow  = (a[MSB] != b[MSB]) && (resultado[MSB] != a[MSB]);
      end
      OP_AND: resultado = a & b;
      OP_OR:  resultado = a | b;
      default: begin
        resultado = {LARGURA{1'b0}};
        overflow  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controle_banco_reg.sv
// Sequencer driving the 3-register bank: write A and B, read back, compute,
// write accumulator, read it back. Macro CHECAGEM_LEITURA_EN adds readback check.
module controle_banco_reg
  import calc_pkg::*;
#(
  parameter int LARGURA = LARGURA_BANCO
) (
  input logic                 Clock,
  input logic                 Reset_n,
  controle_banco_reg_if.master bus
);

  estado_t            estado_r, estado_s;
  logic               aceita_s;
  logic               escrita_r, escrita_s;
  logic [1:0]         idreg_r, idreg_s;
  logic [LARGURA-1:0] dado_r, dado_s;
  logic [1:0]         fonte1_r, fonte1_s;
  logic [1:0]         fonte2_r, fonte2_s;
  logic               ocupado_r, ocupado_s;
  logic               pronto_r, pronto_s;
  logic [LARGURA-1:0] op_b_r;
  logic [1:0]         op_r;
  logic               ovf_r;
  logic [LARGURA-1:0] resultado_r;
  logic               overflow_r;
  logic [LARGURA-1:0] ula_res_s;
  logic               ula_ovf_s;

  assign aceita_s = (estado_r == OCIOSO) && bus.Inicio;

  calc_ula #(.LARGURA(LARGURA)) u_ula (
    .a         (bus.DadoLido1),
    .b         (bus.DadoLido2),
    .op        (op_r),
    .resultado (ula_res_s),
    .overflow  (ula_ovf_s)
  );

  // state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // next state, and bank/status outputs decoded from the state being entered
  always_comb begin
    estado_s  = estado_r;
    escrita_s = 1'b0;
    idreg_s   = idreg_r;
    dado_s    = dado_r;
    fonte1_s  = fonte1_r;
    fonte2_s  = fonte2_r;
    pronto_s  = 1'b0;
    case (estado_r)
      OCIOSO:     estado_s = aceita_s ? ESC_A : OCIOSO;
      ESC_A:      estado_s = ESC_B;
      ESC_B:      estado_s = LER;
      LER:        estado_s = ESPERA;
      ESPERA:     estado_s = ESC_ACC;
      ESC_ACC:    estado_s = LER_ACC;
      LER_ACC:    estado_s = ESPERA_ACC;
      ESPERA_ACC: estado_s = FIM;
      FIM:        estado_s = OCIOSO;
      default:    estado_s = OCIOSO;
    endcase
    ocupado_s = (estado_s != OCIOSO);
    case (estado_s)
      ESC_A: begin
        escrita_s = 1'b1;
        idreg_s   = REG_A;
        dado_s    = bus.OperandoA;
      end
      ESC_B: begin
        escrita_s = 1'b1;
        idreg_s   = REG_B;
        dado_s    = op_b_r;
      end
      LER: begin
        fonte1_s = REG_A;
        fonte2_s = REG_B;
      end
      // dado_r doubles as the result register until the next command
      ESC_ACC: begin
        escrita_s = 1'b1;
        idreg_s   = REG_ACC;
        dado_s    = ula_res_s;
      end
      LER_ACC: begin
        fonte1_s = REG_ACC;
        fonte2_s = REG_ACC;
      end
      FIM:     pronto_s = 1'b1;
      default: escrita_s = 1'b0;
    endcase
  end

  // registered outputs, captured operands and result
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      escrita_r   <= 1'b0;
      idreg_r     <= 2'b00;
      dado_r      <= {LARGURA{1'b0}};
      fonte1_r    <= 2'b00;
      fonte2_r    <= 2'b00;
      ocupado_r   <= 1'b0;
      pronto_r    <= 1'b0;
      op_b_r      <= {LARGURA{1'b0}};
      op_r        <= 2'b00;
      ovf_r       <= 1'b0;
      resultado_r <= {LARGURA{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      escrita_r <= escrita_s;
      idreg_r   <= idreg_s;
      dado_r    <= dado_s;
      fonte1_r  <= fonte1_s;
      fonte2_r  <= fonte2_s;
      ocupado_r <= ocupado_s;
      pronto_r  <= pronto_s;
      if (aceita_s) begin
        op_b_r <= bus.OperandoB;
        op_r   <= bus.Op;
      end
      if (estado_r == ESPERA) begin
        ovf_r <= ula_ovf_s;
      end
      if (estado_r == ESPERA_ACC) begin
        resultado_r <= bus.DadoLido1;
        overflow_r  <= ovf_r;
      end
    end
  end

`ifdef CHECAGEM_LEITURA_EN
  logic erro_r;

  // accumulator readback compared against the value written
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      erro_r <= 1'b0;
    end else if (aceita_s) begin
      erro_r <= 1'b0;
    end else if (estado_r == ESPERA_ACC) begin
      erro_r <= (bus.DadoLido1 != dado_r) | (bus.DadoLido2 != dado_r);
    end else begin
      erro_r <= erro_r;
    end
  end

  assign bus.Erro = erro_r;
`else
  assign bus.Erro = 1'b0;
`endif

  assign bus.Escrita   = escrita_r;
  assign bus.IdReg     = idreg_r;
  assign bus.Dado      = dado_r;
  assign bus.Fonte1    = fonte1_r;
  assign bus.Fonte2    = fonte2_r;
  assign bus.Ocupado   = ocupado_r;
  assign bus.Pronto    = pronto_r;
  assign bus.Resultado = resultado_r;
  assign bus.Overflow  = overflow_r;

endmodule

// File: tb/tb_controle_banco_reg.sv
// Directed bench for controle_banco_reg with a behavioural register bank
// (negedge write, posedge read while Escrita=0).
module tb_controle_banco_reg;
  import calc_pkg::*;

  logic Clock;
  logic Reset_n;
  controle_banco_reg_if bus ();

  controle_banco_reg dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

`ifdef CHECAGEM_LEITURA_EN
  localparam logic ERRO_CORROMPIDO = 1'b1;
`else
  localparam logic ERRO_CORROMPIDO = 1'b0;
`endif

  int testes = 0;
  int falhas = 0;
  logic [31:0] banco [0:2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
  logic corromper = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // bank model write port; optional bit-0 corruption on the accumulator
  always @(negedge Clock) begin
    if (bus.Escrita && bus.IdReg != 2'b11) begin
      if (bus.IdReg == 2'b10 && corromper) banco[bus.IdReg] <= bus.Dado ^ 32'h0000_0001;
      else banco[bus.IdReg] <= bus.Dado;
    end
  end

  // bank model read ports
  always @(posedge Clock) begin
    if (!bus.Escrita) begin
      bus.DadoLido1 <= (bus.Fonte1 == 2'b11) ? 32'h0000_0000 : banco[bus.Fonte1];
      bus.DadoLido2 <= (bus.Fonte2 == 2'b11) ? 32'h0000_0000 : banco[bus.Fonte2];
    end
  end

  task automatic verif(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    testes++;
    if (atual !== esperado) begin
      falhas++;
      $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
    end
  endtask

  task automatic checar_reset(input string nome);
    verif({nome, " Escrita"},   {31'd0, bus.Escrita},  32'h0);
    verif({nome, " IdReg"},     {30'd0, bus.IdReg},    32'h0);
    verif({nome, " Dado"},      bus.Dado,              32'h0);
    verif({nome, " Fonte1"},    {30'd0, bus.Fonte1},   32'h0);
    verif({nome, " Fonte2"},    {30'd0, bus.Fonte2},   32'h0);
    verif({nome, " Resultado"}, bus.Resultado,         32'h0);
    verif({nome, " Ocupado"},   {31'd0, bus.Ocupado},  32'h0);
    verif({nome, " Pronto"},    {31'd0, bus.Pronto},   32'h0);
    verif({nome, " Overflow"},  {31'd0, bus.Overflow}, 32'h0);
    verif({nome, " Erro"},      {31'd0, bus.Erro},     32'h0);
  endtask

  // Presents a command (caller is at a negedge); it is accepted at the next
  // posedge. Samples cycles 1..9 at negedges and returns in cycle 9 (OCIOSO).
  task automatic rodar(input string nome, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] exp_res, input logic exp_ovf,
                       input logic exp_erro, input bit manter, input bit mexer);
    logic [9:1] esc_esp;
    int lat;
    esc_esp = 9'b000010011;
    lat = 0;
    bus.Inicio = 1'b1;
    bus.OperandoA = a;
    bus.OperandoB = b;
    bus.Op = op;
    @(posedge Clock);
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clock);
      if (c == 1 && !manter) bus.Inicio = 1'b0;
      if (c == 2 && mexer) begin
        bus.Inicio = 1'b1;
        bus.OperandoA = ~a;
        bus.OperandoB = 32'h1234_5678;
        bus.Op = ~op;
      end
      if (c == 9 && !manter) bus.Inicio = 1'b0;
      verif($sformatf("%s escrita c%0d", nome, c), {31'd0, bus.Escrita}, {31'd0, esc_esp[c]});
      if (bus.Pronto && lat == 0) lat = c;
      case (c)
        1: begin
          verif({nome, " id A"}, {30'd0, bus.IdReg}, {30'd0, REG_A});
          verif({nome, " dado A"}, bus.Dado, a);
          verif({nome, " ocupado"}, {31'd0, bus.Ocupado}, 32'h1);
        end
        2: begin
          verif({nome, " id B"}, {30'd0, bus.IdReg}, {30'd0, REG_B});
          verif({nome, " dado B"}, bus.Dado, b);
        end
        3: verif({nome, " fontes AB"}, {28'd0, bus.Fonte1, bus.Fonte2}, 32'h1);
        5: verif({nome, " id ACC"}, {30'd0, bus.IdReg}, {30'd0, REG_ACC});
        6: verif({nome, " fontes ACC"}, {28'd0, bus.Fonte1, bus.Fonte2}, 32'hA);
        8: begin
          verif({nome, " resultado"}, bus.Resultado, exp_res);
          verif({nome, " overflow"}, {31'd0, bus.Overflow}, {31'd0, exp_ovf});
          verif({nome, " erro"}, {31'd0, bus.Erro}, {31'd0, exp_erro});
        end
        9: begin
          verif({nome, " pronto fim"}, {31'd0, bus.Pronto}, 32'h0);
          verif({nome, " ocupado fim"}, {31'd0, bus.Ocupado}, 32'h0);
          verif({nome, " resultado retido"}, bus.Resultado, exp_res);
        end
        default: ;
      endcase
    end
    verif({nome, " latencia"}, lat, 32'd8);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        ovf;
  } vetor_t;

  vetor_t vet [10];

  initial begin
    vet[0] = '{32'h0000_0005, 32'h0000_0007, 2'b00, 32'h0000_000C, 1'b0};
    vet[1] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 1'b1};
    vet[2] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00F0_00F0, 1'b0};
    vet[3] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 32'hFFF0_FFF0, 1'b0};
    vet[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 1'b1};
    vet[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b0};
    vet[6] = '{32'h0000_0005, 32'h0000_0007, 2'b01, 32'hFFFF_FFFE, 1'b0};
    vet[7] = '{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 1'b1};
    vet[8] = '{32'h0000_0000, 32'h8000_0000, 2'b01, 32'h8000_0000, 1'b1};
    vet[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 1'b1};

    Reset_n = 1'b0;
    bus.Inicio = 1'b0;
    bus.OperandoA = 32'h0;
    bus.OperandoB = 32'h0;
    bus.Op = 2'b00;
    #12;
    checar_reset("reset");
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 10; i++) begin
      rodar($sformatf("vet%0d", i), vet[i].a, vet[i].b, vet[i].op, vet[i].res, vet[i].ovf,
            1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        verif("banco r0", banco[0], 32'h0000_0005);
        verif("banco r1", banco[1], 32'h0000_0007);
        verif("banco r2", banco[2], 32'h0000_000C);
      end
    end

    // Inicio held high: commands every 9 cycles
    rodar("b2b0", 32'h0000_0010, 32'h0000_0003, 2'b01, 32'h0000_000D, 1'b0, 1'b0, 1'b1, 1'b0);
    rodar("b2b1", 32'h0000_0100, 32'h0000_0023, 2'b00, 32'h0000_0123, 1'b0, 1'b0, 1'b1, 1'b0);
    rodar("b2b2", 32'h0000_00FF, 32'h0000_0F0F, 2'b10, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);

    // operand and Inicio changes while busy are ignored
    rodar("mexer", 32'h0000_1000, 32'h0000_0001, 2'b01, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // corrupted accumulator readback
    corromper = 1'b1;
    rodar("corrompe", 32'h0000_0005, 32'h0000_0007, 2'b00, 32'h0000_000D, 1'b0,
          ERRO_CORROMPIDO, 1'b0, 1'b0);
    corromper = 1'b0;
    rodar("limpa erro", 32'h0000_0002, 32'h0000_0003, 2'b11, 32'h0000_0003, 1'b0,
          1'b0, 1'b0, 1'b0);

    // reset during ESPERA
    bus.Inicio = 1'b1;
    bus.OperandoA = 32'h0000_0009;
    bus.OperandoB = 32'h0000_0001;
    bus.Op = 2'b00;
    @(posedge Clock);
    @(negedge Clock);
    bus.Inicio = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1 checar_reset("reset meio");
    @(negedge Clock);
    Reset_n = 1'b1;
    rodar("pos reset", 32'h0000_0009, 32'h0000_0001, 2'b00, 32'h0000_000A, 1'b0,
          1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
